// File: rtl/stepper_pkg.sv
// Shared types and coil decode for the two-phase bipolar stepper controller.
package stepper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-winding H-bridge pair {hi, lo}; {1,1} would short the bridge and is never produced.
  localparam logic [1:0] COIL_POS = 2'b10;
  localparam logic [1:0] COIL_NEG = 2'b01;
  localparam logic [1:0] COIL_OFF = 2'b00;

  // Phase 0..7 -> {x, xb, y, yb}; even phases reproduce the legacy full-step sequence.
  function automatic logic [3:0] phase_coils(input logic [2:0] p);
    logic [1:0] a, b;
    a = COIL_OFF;
    b = COIL_OFF;
    unique case (p)
      3'd0: begin a = COIL_NEG; b = COIL_NEG; end
      3'd1: begin a = COIL_OFF; b = COIL_NEG; end
      3'd2: begin a = COIL_POS; b = COIL_NEG; end
      3'd3: begin a = COIL_POS; b = COIL_OFF; end
      3'd4: begin a = COIL_POS; b = COIL_POS; end
      3'd5: begin a = COIL_OFF; b = COIL_POS; end
      3'd6: begin a = COIL_NEG; b = COIL_POS; end
      3'd7: begin a = COIL_NEG; b = COIL_OFF; end
      default: begin a = COIL_OFF; b = COIL_OFF; end
    endcase
    return {a, b};
  endfunction

endpackage

// File: rtl/step_divider.sv
// Step-rate divider: reloadable down-counter that pulses tick for one cycle on expiry.
module step_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] rld;

  assign tick = en && (cnt == '0);

  // The reload value is captured on load so the counter free-runs at the same period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rld <= '0;
    end else if (load) begin
      cnt <= load_val;
      rld <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? rld : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/stepper_ctrl.sv
// Two-phase bipolar stepper controller: command latch, IDLE/RUN FSM, phase/position
// tracking and registered H-bridge outputs.
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 24,
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_half,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic [POS_W-1:0] pos,
  output logic             x,
  output logic             xb,
  output logic             y,
  output logic             yb
);

  state_t           state, state_n;
  logic             dir_q, half_q;
  logic [CNT_W-1:0] steps_left_q;
  logic [2:0]       phase, phase_step, phase_n;
  logic [2:0]       delta;
  logic [POS_W-1:0] pos_q, pos_step;
  logic [3:0]       coils_q;
  logic             done_q, done_n;
  logic             accept, do_step, tick;
  logic [DIV_W-1:0] per_m1;

  // A period of 0 behaves as 1, i.e. a step every clock.
  assign per_m1 = (cmd_period == '0) ? '0 : cmd_period - 1'b1;

  step_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (state == RUN),
    .load_val (per_m1),
    .tick     (tick)
  );

  assign cmd_ready = (state == IDLE) && !abort;
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    do_step = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if (cmd_steps == '0) done_n  = 1'b1;
          else                 state_n = RUN;
        end
      end
      RUN: begin
        // Abort takes priority over a step that would land on the same edge.
        if (abort) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (tick) begin
          do_step = 1'b1;
          if (steps_left_q == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Full-step from an odd phase takes a single half-step first to realign to even phases.
  assign delta      = (half_q || phase[0]) ? 3'd1 : 3'd2;
  assign phase_step = dir_q ? phase + delta : phase - delta;
  assign pos_step   = dir_q ? pos_q + POS_W'(delta) : pos_q - POS_W'(delta);
  assign phase_n    = do_step ? phase_step : phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      steps_left_q <= '0;
      phase        <= '0;
      pos_q        <= '0;
      done_q       <= 1'b0;
      coils_q      <= HOLD ? phase_coils(3'd0) : 4'b0000;
    end else begin
      done_q  <= done_n;
      coils_q <= ((state_n == RUN) || HOLD) ? phase_coils(phase_n) : 4'b0000;
      if (accept) begin
        dir_q        <= cmd_dir;
        half_q       <= cmd_half;
        steps_left_q <= cmd_steps;
      end else if (do_step) begin
        phase        <= phase_step;
        pos_q        <= pos_step;
        steps_left_q <= steps_left_q - 1'b1;
      end
    end
  end

  assign done           = done_q;
  assign steps_left     = steps_left_q;
  assign pos            = pos_q;
  assign {x, xb, y, yb} = coils_q;

endmodule

// File: doc/stepper_ctrl.md
# stepper_ctrl

Parametrised two-phase bipolar stepper controller: accepts move commands (step count, direction, full/half-step mode, step period) over a valid/ready handshake. It sequences the H-bridge lines `x`/`xb` (coil A) and `y`/`yb` (coil B) at a programmable rate and tracks a signed position. It sits between the elevator floor/motion controller and the motor driver pins, replacing the free-running fixed-rate full-step driver.

## Interface
- `CNT_W`, 16, width of step count / steps_left
- `DIV_W`, 16, width of step period in clocks
- `POS_W`, 24, width of signed position counter (half-step units)
- `HOLD`, 1, 1 = coils stay energised at last phase when idle; 0 = all coil lines 0 when idle
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept (idle, not aborting)
- `cmd_steps`  in  CNT_W  steps to move (units of the selected mode)
- `cmd_dir`  in  1  1 = forward (phase increments), 0 = reverse
- `cmd_half`  in  1  1 = half-step mode, 0 = full-step mode
- `cmd_period`  in  DIV_W  clocks per step; 0 treated as 1
- `abort`  in  1  stop current move at next edge
- `busy`  out  1  move in progress
- `done`  out  1  one-cycle pulse at move completion or abort
- `steps_left`  out  CNT_W  remaining steps of current/last move
- `pos`  out  POS_W  signed position, half-step units, wraps mod 2^POS_W
- `x`, `xb`, `y`, `yb`  out  1 each  coil drive lines, registered

## Operation
- Coil state: A+ = x1 xb0, A− = x0 xb1, A0 = x0 xb0; same for B with y/yb. x=xb=1 never driven.
- 3-bit phase p: p0 A−B−, p1 A0B−, p2 A+B−, p3 A+B0, p4 A+B+, p5 A0B+, p6 A−B+, p7 A−B0. Even phases = the legacy full-step sequence.
- States IDLE, RUN. IDLE: cmd_ready=1 unless abort=1. Accept on cmd_valid&&cmd_ready: latch dir, half, period (0→1), load steps_left=cmd_steps, divider=period−1, go RUN.
- cmd_steps=0: accepted, stays IDLE, done pulses next cycle, no phase change.
- RUN: divider counts down; at 0 a step occurs: phase ±1 (half) or ±2 (full), steps_left−1, pos ±1 (half) or ±2 (full), divider reloads period−1.
- Full-step from odd phase: first step moves ±1 to reach an even phase (pos ±1); later steps ±2.
- Phase wraps 7↔0; pos wraps two's-complement.
- Last step (steps_left 1→0): same edge goes IDLE, done=1 for next cycle.
- abort in RUN: next edge IDLE, done pulses, no step even if the divider expires that cycle (abort wins), steps_left keeps the remainder.
- Coils: RUN always drives decoded phase; IDLE drives decoded phase if HOLD=1, else all 0.

## Timing
- Reset: state IDLE, phase 0, pos 0, steps_left 0, busy 0, done 0, cmd_ready 1; x=0,y=0; xb=yb=1 if HOLD=1 else 0.
- busy=1 from the cycle after acceptance until the edge that returns to IDLE.
- First coil change appears cmd_period cycles after the accept edge; subsequent changes every cmd_period cycles.
- Coil lines, pos, steps_left update on the same edge as the phase.
- New command accepted earliest in the done cycle (back-to-back; no gap step).
- Reset mid-move: immediate return to reset values; move is discarded.

## Structure
- Package `stepper_pkg`: state enum (IDLE, RUN), coil-state constants, function mapping 3-bit phase → {x,xb,y,yb}.
- Sub-module `step_divider`: DIV_W down-counter with load/enable and one-cycle `tick` on expiry.
- Top: command latch, FSM, phase/pos/steps_left counters, output registers.

## Test plan
- Reset, HOLD=1 → x0 xb1 y0 yb1, cmd_ready=1, pos=0.
- Full, fwd, steps=4, period=3 → phases 2,4,6,0 at accept+3,+6,+9,+12; pos=8; done one cycle after last step.
- Half, rev, steps=3, period=1 from p0 → phases 7,6,5 on consecutive cycles; pos=−3; steps_left=0.
- Half fwd 1 step (p→1), then full fwd 2 steps → phases 2 then 4; pos=1→2→4.
- Abort in the divider-expiry cycle of step 2 of 5 → no second step, done pulses, steps_left=4, cmd_ready=1 next cycle.
- steps=0 → no coil change, done next cycle; HOLD=0 build → coils 0 in IDLE, driven during RUN.
